// File: rtl/rf_wport_sched_pkg.sv
// Shared types and constants for the register-file write-port scheduler.
// Holds the register/data widths, the zero-register constant and the grant encoding.
package rf_wport_sched_pkg;

    localparam int REG_W    = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 1 << REG_W;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_MDU  = 2'd2
    } gnt_e;

    typedef struct packed {
        logic [REG_W-1:0]  addr;
        logic [DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rf_wport_sched_if.sv
// Bundle of producer, decode and register-file signals around rf_wport_sched.
// The forwarding outputs exist only when RF_WPORT_FWD_EN is defined.
interface rf_wport_sched_if
    import rf_wport_sched_pkg::*;
();
    logic              wb_valid;
    logic [REG_W-1:0]  wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              mdu_valid;
    logic              mdu_ready;
    logic [REG_W-1:0]  mdu_addr;
    logic [DATA_W-1:0] mdu_data;
    logic              issue_valid;
    logic [REG_W-1:0]  issue_rd;
    logic              issue_ready;
    logic [REG_W-1:0]  r1_addr;
    logic [REG_W-1:0]  r2_addr;
    logic              hazard;
    logic              pipe_stall;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
`ifdef RF_WPORT_FWD_EN
    logic              fwd1_hit;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic [DATA_W-1:0] fwd2_data;
`endif

    modport master (
        output wb_valid, wb_addr, wb_data,
        output mdu_valid, mdu_addr, mdu_data,
        output issue_valid, issue_rd, r1_addr, r2_addr,
        input  mdu_ready, issue_ready, hazard, pipe_stall,
        input  rf_we, rf_waddr, rf_wdata
`ifdef RF_WPORT_FWD_EN
        , input fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
`endif
    );

    modport slave (
        input  wb_valid, wb_addr, wb_data,
        input  mdu_valid, mdu_addr, mdu_data,
        input  issue_valid, issue_rd, r1_addr, r2_addr,
        output mdu_ready, issue_ready, hazard, pipe_stall,
        output rf_we, rf_waddr, rf_wdata
`ifdef RF_WPORT_FWD_EN
        , output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data
`endif
    );

endinterface

// File: rtl/rf_sb_pending.sv
// Pending-destination scoreboard: one bit per register, set on MDU issue, cleared on write.
// A same-cycle set and clear of one bit leaves it set; register 0 is never pending.
module rf_sb_pending
    import rf_wport_sched_pkg::*;
#(
    parameter int N_LOOK = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          set_i,
    input  logic [REG_W-1:0]              set_addr_i,
    input  logic                          clr_i,
    input  logic [REG_W-1:0]              clr_addr_i,
    input  logic [N_LOOK-1:0][REG_W-1:0]  look_addr_i,
    output logic [N_LOOK-1:0]             look_pend_o
);

    logic [NUM_REGS-1:0] pend_q, pend_d;

    always_comb begin
        pend_d = pend_q;
        if (clr_i)
            pend_d[clr_addr_i] = 1'b0;
        if (set_i && set_addr_i != REG_ZERO)
            pend_d[set_addr_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pend_q <= '0;
        else
            pend_q <= pend_d;
    end

    for (genvar g = 0; g < N_LOOK; g++) begin : g_look
        assign look_pend_o[g] = (look_addr_i[g] != REG_ZERO) && pend_q[look_addr_i[g]];
    end

endmodule

// File: rtl/rf_wport_sched.sv
// Arbitrates the single register-file write port between WB and a skid-buffered MDU result,
// with starvation-bounded WB priority and a pending scoreboard. Option: RF_WPORT_FWD_EN.
module rf_wport_sched
    import rf_wport_sched_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst,
    rf_wport_sched_if.slave  bus
);

    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    logic              full_q, full_d;
    wr_req_t           skid_q, skid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    gnt_e              gnt;
    logic              stall;
    logic              wb_use;
    logic              drain;
    logic              accept;
    logic              we;
    logic [REG_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
    logic              sb_set;
    logic [2:0]        look_pend;

    // A WB write to register 0 is not a real port use, so it never blocks a full skid.
    always_comb begin
        stall  = full_q && (cnt_q == STARVE_LIM);
        wb_use = bus.wb_valid && (bus.wb_addr != REG_ZERO);
        if (stall)
            gnt = GNT_MDU;
        else if (wb_use || (bus.wb_valid && !full_q))
            gnt = GNT_WB;
        else if (full_q)
            gnt = GNT_MDU;
        else
            gnt = GNT_NONE;
    end

    assign drain = (gnt == GNT_MDU);

    always_comb begin
        we    = 1'b0;
        waddr = REG_ZERO;
        wdata = '0;
        case (gnt)
            GNT_WB: begin
                we    = wb_use;
                waddr = bus.wb_addr;
                wdata = bus.wb_data;
            end
            GNT_MDU: begin
                we    = (skid_q.addr != REG_ZERO);
                waddr = skid_q.addr;
                wdata = skid_q.data;
            end
            default: ;
        endcase
    end

    assign bus.mdu_ready = !full_q || drain;
    assign accept        = bus.mdu_valid && bus.mdu_ready;

    always_comb begin
        full_d = full_q;
        skid_d = skid_q;
        if (drain)
            full_d = 1'b0;
        if (accept) begin
            full_d      = 1'b1;
            skid_d.addr = bus.mdu_addr;
            skid_d.data = bus.mdu_data;
        end
    end

    // Counts cycles a buffered result loses the port; reaching the limit forces a drain.
    always_comb begin
        cnt_d = cnt_q;
        if (drain)
            cnt_d = '0;
        else if (full_q)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q <= 1'b0;
            skid_q <= '0;
            cnt_q  <= '0;
        end else begin
            full_q <= full_d;
            skid_q <= skid_d;
            cnt_q  <= cnt_d;
        end
    end

    rf_sb_pending #(.N_LOOK(3)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .set_i       (sb_set),
        .set_addr_i  (bus.issue_rd),
        .clr_i       (drain),
        .clr_addr_i  (skid_q.addr),
        .look_addr_i ({bus.issue_rd, bus.r2_addr, bus.r1_addr}),
        .look_pend_o (look_pend)
    );

    assign bus.issue_ready = !look_pend[2] || (drain && skid_q.addr == bus.issue_rd);
    assign sb_set          = bus.issue_valid && bus.issue_ready && (bus.issue_rd != REG_ZERO);

    assign bus.pipe_stall = stall;
    assign bus.rf_we      = we;
    assign bus.rf_waddr   = waddr;
    assign bus.rf_wdata   = wdata;

`ifdef RF_WPORT_FWD_EN
    logic drain_r1, drain_r2;

    // The result being written this cycle is bypassed, so its register no longer stalls decode.
    assign drain_r1   = drain && (skid_q.addr == bus.r1_addr);
    assign drain_r2   = drain && (skid_q.addr == bus.r2_addr);
    assign bus.hazard = (look_pend[0] && !drain_r1) || (look_pend[1] && !drain_r2);

    assign bus.fwd1_hit  = we && (waddr == bus.r1_addr) && (bus.r1_addr != REG_ZERO);
    assign bus.fwd2_hit  = we && (waddr == bus.r2_addr) && (bus.r2_addr != REG_ZERO);
    assign bus.fwd1_data = wdata;
    assign bus.fwd2_data = wdata;
`else
    assign bus.hazard = look_pend[0] || look_pend[1];
`endif

endmodule

// File: tb/tb_rf_wport_sched.sv
// Bench for rf_wport_sched: cycle vectors with expected port outputs, plus a write-order
// scoreboard and a hand-built asynchronous reset sequence.
module tb_rf_wport_sched;
    import rf_wport_sched_pkg::*;

    typedef struct {
        logic        wv;  logic [4:0] wa;  logic [31:0] wd;
        logic        mv;  logic [4:0] ma;  logic [31:0] md;
        logic        iv;  logic [4:0] ir;  logic [4:0]  r1; logic [4:0] r2;
        logic        we;  logic [4:0] ea;  logic [31:0] ed;
        logic        mrdy; logic irdy; logic hz; logic hzf; logic st;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rf_wport_sched_if bus();

    rf_wport_sched #(.STARVE_MAX(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    int   checks = 0;
    int   errors = 0;
    wr_t  expq[$];
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int wv, input int wa, input logic [31:0] wd,
                                input int mv, input int ma, input logic [31:0] md,
                                input int iv, input int ir, input int r1, input int r2,
                                input int we, input int ea, input logic [31:0] ed,
                                input int mrdy, input int irdy, input int hz, input int hzf,
                                input int st);
        vec_t v;
        v.wv = (wv != 0); v.wa = wa[4:0]; v.wd = wd;
        v.mv = (mv != 0); v.ma = ma[4:0]; v.md = md;
        v.iv = (iv != 0); v.ir = ir[4:0]; v.r1 = r1[4:0]; v.r2 = r2[4:0];
        v.we = (we != 0); v.ea = ea[4:0]; v.ed = ed;
        v.mrdy = (mrdy != 0); v.irdy = (irdy != 0);
        v.hz = (hz != 0); v.hzf = (hzf != 0); v.st = (st != 0);
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.wb_valid    = v.wv; bus.wb_addr  = v.wa; bus.wb_data  = v.wd;
        bus.mdu_valid   = v.mv; bus.mdu_addr = v.ma; bus.mdu_data = v.md;
        bus.issue_valid = v.iv; bus.issue_rd = v.ir;
        bus.r1_addr     = v.r1; bus.r2_addr  = v.r2;
    endtask

    task automatic apply(input vec_t v, input string tag);
        wr_t w;
        @(posedge clk);
        #1;
        drive(v);
        if (v.we) expq.push_back({v.ea, v.ed});
        @(negedge clk);
        chk({tag, " rf_we"},       32'(bus.rf_we),       32'(v.we));
        chk({tag, " mdu_ready"},   32'(bus.mdu_ready),   32'(v.mrdy));
        chk({tag, " issue_ready"}, 32'(bus.issue_ready), 32'(v.irdy));
        chk({tag, " pipe_stall"},  32'(bus.pipe_stall),  32'(v.st));
`ifdef RF_WPORT_FWD_EN
        chk({tag, " hazard"},      32'(bus.hazard),      32'(v.hzf));
        chk({tag, " fwd1_hit"}, 32'(bus.fwd1_hit), 32'(v.we && v.ea == v.r1 && v.r1 != 5'd0));
        chk({tag, " fwd2_hit"}, 32'(bus.fwd2_hit), 32'(v.we && v.ea == v.r2 && v.r2 != 5'd0));
        if (v.we && v.ea == v.r2 && v.r2 != 5'd0)
            chk({tag, " fwd2_data"}, bus.fwd2_data, v.ed);
`else
        chk({tag, " hazard"},      32'(bus.hazard),      32'(v.hz));
`endif
        if (bus.rf_we) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s unexpected write addr=%0d data=%0h", tag, bus.rf_waddr, bus.rf_wdata);
            end else begin
                w = expq.pop_front();
                chk({tag, " rf_waddr"}, 32'(bus.rf_waddr), 32'(w.a));
                chk({tag, " rf_wdata"}, bus.rf_wdata, w.d);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        //             wv wa wd              mv ma md             iv ir r1 r2  we ea ed             mr ir hz hf st
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 3, 32'hDEADBEEF, 0, 0, 32'h0,         0, 0, 0, 0,  1, 3, 32'hDEADBEEF, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h1234,     0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 8, 8, 0,  0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 8, 32'hA5A50008,  0, 8, 8, 0,  0, 0, 32'h0,        1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 8, 8, 0,  1, 8, 32'hA5A50008, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 8, 8, 0,  0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 5, 5, 0,  0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 5, 32'h55,        1, 5, 5, 0,  0, 0, 32'h0,        1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         1, 5, 5, 0,  1, 5, 32'h55,       1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 5, 5, 0,  0, 0, 32'h0,        1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 5, 32'h66,        0, 5, 5, 0,  0, 0, 32'h0,        1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 5, 5, 0,  1, 5, 32'h66,       1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 5, 5, 0,  0, 0, 32'h0,        1, 1, 0, 0, 0));
        // starvation: four lost cycles, then one stall cycle that drains the skid
        tbl.push_back(mk(1, 1, 32'h11,       1, 9, 32'h99,        0, 0, 0, 0,  1, 1, 32'h11,       1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 2, 32'h22,       0, 0, 32'h0,         0, 0, 0, 0,  1, 2, 32'h22,       0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 3, 32'h33,       0, 0, 32'h0,         0, 0, 0, 0,  1, 3, 32'h33,       0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 4, 32'h44,       0, 0, 32'h0,         0, 0, 0, 0,  1, 4, 32'h44,       0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 5, 32'h55,       0, 0, 32'h0,         0, 0, 0, 0,  1, 5, 32'h55,       0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 6, 32'h66,       0, 0, 32'h0,         0, 0, 0, 0,  1, 9, 32'h99,       1, 1, 0, 0, 1));
        tbl.push_back(mk(1, 6, 32'h66,       0, 0, 32'h0,         0, 0, 0, 0,  1, 6, 32'h66,       1, 1, 0, 0, 0));
        // load and drain in the same cycle, forwarding on r2
        tbl.push_back(mk(0, 0, 32'h0,        1, 10, 32'hA0,       0, 0, 0, 0,  0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 11, 32'hB1,       0, 0, 0, 10, 1, 10, 32'hA0,      1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 0, 0, 11, 1, 11, 32'hB1,      1, 1, 0, 0, 0));
        // WB to r0 yields the port; MDU result to r0 drains silently
        tbl.push_back(mk(0, 0, 32'h0,        1, 12, 32'hC2,       0, 0, 0, 0,  0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h77,       0, 0, 32'h0,         0, 0, 0, 0,  1, 12, 32'hC2,      1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        1, 0, 32'hFF,        0, 0, 0, 0,  0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 32'h0,        1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 7, 32'h70,       1, 13, 32'hD3,       0, 0, 0, 0,  1, 7, 32'h70,       1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 0, 0, 0,  1, 13, 32'hD3,      1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 32'h0,        1, 1, 0, 0, 0));

        drive(tbl[0]);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset mdu_ready",   32'(bus.mdu_ready),   32'd1);
        chk("reset issue_ready", 32'(bus.issue_ready), 32'd1);
        chk("reset hazard",      32'(bus.hazard),      32'd0);
        chk("reset pipe_stall",  32'(bus.pipe_stall),  32'd0);
        chk("reset rf_we",       32'(bus.rf_we),       32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++)
            apply(tbl[i], $sformatf("v%0d", i));

        // Reset while the skid holds a result for r8 and pend = 0x0000_0100.
        apply(mk(0, 0, 32'h0, 0, 0, 32'h0,  1, 8, 8, 0,  0, 0, 32'h0, 1, 1, 0, 0, 0), "r0");
        apply(mk(1, 1, 32'h1, 1, 8, 32'h88, 0, 8, 8, 0,  1, 1, 32'h1, 1, 0, 1, 1, 0), "r1");
        apply(mk(1, 2, 32'h2, 0, 0, 32'h0,  0, 8, 8, 0,  1, 2, 32'h2, 0, 0, 1, 1, 0), "r2");
        #2;
        rst_n = 1'b0;
        drive(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 8, 8, 0, 0, 0, 32'h0, 1, 1, 0, 0, 0));
        #1;
        chk("midrst mdu_ready",   32'(bus.mdu_ready),   32'd1);
        chk("midrst rf_we",       32'(bus.rf_we),       32'd0);
        chk("midrst hazard",      32'(bus.hazard),      32'd0);
        chk("midrst issue_ready", 32'(bus.issue_ready), 32'd1);
        chk("midrst pipe_stall",  32'(bus.pipe_stall),  32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        apply(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 8, 8, 0, 0, 0, 32'h0, 1, 1, 0, 0, 0), "r3");
        apply(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 8, 8, 0, 0, 0, 32'h0, 1, 1, 0, 0, 0), "r4");

        chk("scoreboard drained", 32'(expq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
